// File: rtl/leaf_rr_arbiter.sv
// Round-robin arbiter sharing one resource among N_REQ leaf requesters.
// Grants are held until done, request drop, or a tenure timeout.
module leaf_rr_arbiter #(
    parameter int N_REQ   = 5,
    parameter int TIMEOUT = 16,
    parameter int ID_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             busy,
    output logic             timeout_pulse,
    output logic [15:0]      grant_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_REL
    } state_t;

    localparam logic [7:0]      TEN_MAX = 8'(TIMEOUT - 1);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(N_REQ - 1);

    state_t           r_state;
    logic [N_REQ-1:0] r_grant;
    logic [ID_W-1:0]  r_id;
    logic [ID_W-1:0]  r_ptr;
    logic             r_busy;
    logic             r_to;
    logic [15:0]      r_cnt;
    logic [7:0]       r_ten;

    logic             w_any;
    logic [ID_W-1:0]  w_sel;
    int               w_j;
    logic             w_own_done;
    logic             w_own_req;
    logic             w_end;

    // Scan downward so the lowest offset from the pointer wins.
    always_comb begin
        w_sel = '0;
        w_j   = 0;
        w_any = |req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_j = int'(r_ptr) + i;
            if (w_j >= N_REQ) begin
                w_j = w_j - N_REQ;
            end
            if (req[w_j]) begin
                w_sel = ID_W'(w_j);
            end
        end
    end

    assign w_own_done = done[r_id];
    assign w_own_req  = req[r_id];
    assign w_end      = w_own_done || !w_own_req || (r_ten == TEN_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
            r_to    <= 1'b0;
            r_cnt   <= '0;
            r_ten   <= '0;
        end else begin
            r_to <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= N_REQ'(1) << w_sel;
                        r_id    <= w_sel;
                        r_busy  <= 1'b1;
                        r_cnt   <= r_cnt + 16'd1;
                        r_ten   <= '0;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_end) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= (r_id == ID_LAST) ? '0 : r_id + ID_W'(1);
                        // done takes priority, so a same-cycle done is not a timeout
                        r_to    <= !w_own_done && w_own_req;
                        r_state <= S_REL;
                    end else begin
                        r_ten <= r_ten + 8'd1;
                    end
                end
                S_REL: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant         = r_grant;
    assign grant_id      = r_id;
    assign busy          = r_busy;
    assign timeout_pulse = r_to;
    assign grant_cnt     = r_cnt;

endmodule

// File: tb/tb_leaf_rr_arbiter.sv
// Bench for leaf_rr_arbiter: directed scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_leaf_rr_arbiter;

    localparam int N  = 5;
    localparam int TO = 16;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  done;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_id;
    logic          busy;
    logic          timeout_pulse;
    logic [15:0]   grant_cnt;

    int vec = 0;
    int bad = 0;

    // Model: owner (-1 = none), cycles held, cooldown edges before arbitration
    int          m_owner;
    int          m_ptr;
    int          m_held;
    int          m_cool;
    logic        m_to;
    logic [15:0] m_cnt;
    int          order[$];

    leaf_rr_arbiter #(
        .N_REQ  (N),
        .TIMEOUT(TO),
        .ID_W   (IW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .done         (done),
        .grant        (grant),
        .grant_id     (grant_id),
        .busy         (busy),
        .timeout_pulse(timeout_pulse),
        .grant_cnt    (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic [N-1:0] rq,
                         input logic [N-1:0] dn);
        bit found;
        int idx;
        if (!r) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_cool  = 0;
            m_to    = 1'b0;
            m_cnt   = '0;
        end else begin
            m_to = 1'b0;
            if (m_owner >= 0) begin
                if (dn[m_owner] || !rq[m_owner] || m_held == TO) begin
                    m_to    = !dn[m_owner] && rq[m_owner];
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                    m_cool  = 1;
                end else begin
                    m_held++;
                end
            end else if (m_cool > 0) begin
                m_cool--;
            end else if (rq != '0) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (!found && rq[idx]) begin
                        found   = 1;
                        m_owner = idx;
                    end
                end
                m_held = 1;
                m_cnt  = m_cnt + 16'd1;
                order.push_back(m_owner);
            end
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] rq,
                        input logic [N-1:0] dn);
        logic [N-1:0] eg;
        rst_n = r;
        req   = rq;
        done  = dn;
        @(posedge clk);
        model(r, rq, dn);
        #1;
        eg = (m_owner >= 0) ? N'(1) << m_owner : '0;
        chk("grant", 32'(grant), 32'(eg));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("timeout_pulse", 32'(timeout_pulse), 32'(m_to));
        chk("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
        chk("onehot0", 32'($onehot0(grant)), 32'd1);
        if (m_owner >= 0) begin
            chk("grant_id", 32'(grant_id), 32'(m_owner));
        end
    endtask

    function automatic logic [N-1:0] owner_done();
        return (m_owner >= 0 && m_held == 3) ? N'(1) << m_owner : '0;
    endfunction

    initial begin
        int zeros;
        int held;
        int guard;
        logic [N-1:0] rq;
        logic [N-1:0] dn;

        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        m_owner = -1;
        m_ptr = 0;
        m_held = 0;
        m_cool = 0;
        m_to = 1'b0;
        m_cnt = '0;

        // Reset with all requests raised
        step(1'b0, 5'b11111, '0);
        step(1'b0, 5'b11111, '0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_id", 32'(grant_id), 32'd0);
        chk("rst_cnt", 32'(grant_cnt), 32'd0);
        step(1'b1, 5'b00100, '0);
        chk("first_grant", 32'(grant), 32'h04);
        chk("first_id", 32'(grant_id), 32'd2);
        chk("first_cnt", 32'(grant_cnt), 32'd1);
        step(1'b1, '0, '0);
        step(1'b1, '0, '0);

        // Round-robin with every leaf requesting
        step(1'b0, '0, '0);
        order.delete();
        zeros = 0;
        guard = 0;
        while (order.size() < 6 && guard < 80) begin
            step(1'b1, 5'b11111, owner_done());
            if (grant == '0 && order.size() > 0 && order.size() < 6)
                zeros++;
            guard++;
        end
        chk("rr_len", 32'(order.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < order.size())
                chk("rr_order", 32'(order[i]), 32'(i % N));
        end
        chk("rr_gap", 32'(zeros), 32'd10);
        chk("rr_cnt", 32'(grant_cnt), 32'd6);

        // Timeout on leaf 1
        step(1'b1, '0, '0);
        step(1'b1, '0, '0);
        step(1'b1, '0, '0);
        held = 0;
        guard = 0;
        while (!timeout_pulse && guard < 40) begin
            step(1'b1, 5'b00010, '0);
            if (grant == 5'b00010) held++;
            guard++;
        end
        chk("to_seen", 32'(timeout_pulse), 32'd1);
        chk("to_held", 32'(held), 32'd16);
        chk("to_grant", 32'(grant), 32'd0);
        step(1'b1, 5'b00010, '0);
        chk("to_pulse_len", 32'(timeout_pulse), 32'd0);
        // Done coinciding with timeout is a normal release
        guard = 0;
        while (!(m_owner == 1 && m_held == TO) && guard < 40) begin
            step(1'b1, 5'b00010, '0);
            guard++;
        end
        step(1'b1, 5'b00010, 5'b00010);
        chk("done_vs_to", 32'(timeout_pulse), 32'd0);
        chk("done_vs_to_gnt", 32'(grant), 32'd0);
        step(1'b1, 5'b00101, '0);
        step(1'b1, 5'b00101, '0);
        chk("ptr_after_1", 32'(grant), 32'h04);

        // Owner 3 drops its request while leaf 0 waits
        step(1'b0, '0, '0);
        step(1'b1, 5'b01000, '0);
        chk("drop_own", 32'(grant), 32'h08);
        step(1'b1, 5'b00001, '0);
        chk("drop_clr", 32'(grant), 32'd0);
        step(1'b1, 5'b00001, '0);
        chk("drop_gap", 32'(grant), 32'd0);
        step(1'b1, 5'b00001, '0);
        chk("drop_next", 32'(grant), 32'h01);

        // Done from a non-owner is ignored
        step(1'b0, '0, '0);
        step(1'b1, 5'b00010, '0);
        step(1'b1, 5'b00010, 5'b10000);
        chk("foreign_done", 32'(grant), 32'h02);
        step(1'b1, 5'b00010, 5'b00010);
        chk("own_done", 32'(grant), 32'd0);

        // Reset in the middle of a tenure
        step(1'b0, '0, '0);
        step(1'b1, 5'b10000, '0);
        chk("mid_own", 32'(grant), 32'h10);
        step(1'b0, 5'b10001, '0);
        chk("mid_rst_gnt", 32'(grant), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        step(1'b1, 5'b10001, '0);
        chk("mid_after", 32'(grant), 32'h01);

        // Random traffic: requests mostly held, sporadic done and reset
        rq = '0;
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 9) == 0) rq[b] = ~rq[b];
            end
            dn = '0;
            if ($urandom_range(0, 3) == 0) dn = N'($urandom);
            step(($urandom_range(0, 99) != 0), rq, dn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/leaf_rr_arbiter.md
Name: leaf_rr_arbiter

Overview:
- Round-robin arbiter that shares one common resource (bus/config port) among the five leaf instances (indices 0..4) under a root module.
- Each leaf raises a request and holds it. The arbiter grants exactly one leaf at a time and holds the grant until that leaf signals done, drops its request, or times out.
- Sits in the root module, alongside the five leaf instances.

Parameters:
- N_REQ, 5, number of requesters (1..8).
- TIMEOUT, 16, maximum grant tenure in clock cycles before forced release (2..255).
- ID_W, 3, width of grant_id; must satisfy 2**ID_W >= N_REQ.

Ports:
- clk  input  1  single clock; everything is sampled on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  N_REQ  per-leaf request; level, held until the tenure ends.
- done  input  N_REQ  per-leaf end-of-tenure pulse; only the bit of the current owner is honoured.
- grant  output  N_REQ  one-hot grant, registered; all zero when no owner.
- grant_id  output  ID_W  index of the current owner; valid only while busy=1.
- busy  output  1  high while any grant is asserted.
- timeout_pulse  output  1  one-cycle pulse when a tenure is forcibly ended.
- grant_cnt  output  16  total number of grants issued since reset; wraps.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - grant=0, grant_id=0, busy=0, timeout_pulse=0, grant_cnt=0.
  - State=IDLE, round-robin pointer=0, tenure counter=0.
  - Reset mid-tenure drops the grant on the very next edge.
- State IDLE:
  - If any req bit is set, select the first set bit searching upward from the pointer with wrap-around (pointer, pointer+1, ..., N_REQ-1, 0, ...).
  - On the next edge: grant gets that one-hot bit, grant_id the index, busy=1, grant_cnt+1, state moves to GRANT, tenure counter cleared.
  - Latency is 1 cycle from req sampled to grant visible.
- State GRANT:
  - The tenure counter increments every cycle.
  - The tenure ends when any of the following holds, evaluated with this priority:
    1. done[owner]=1,
    2. req[owner]=0,
    3. tenure counter reaches TIMEOUT-1 (the owner has held the grant TIMEOUT cycles).
  - On end of tenure: the next edge clears grant, clears busy, sets pointer=(owner+1) mod N_REQ, and moves to RELEASE.
  - If the end was caused by timeout, timeout_pulse=1 for exactly that one cycle.
  - done and req changes on non-owner bits are ignored while in GRANT.
- State RELEASE:
  - One mandatory idle cycle with grant=0, so no back-to-back overlap between owners.
  - Then go to IDLE.
  - Requests present in RELEASE are arbitrated in IDLE on the following edge, so the minimum gap between successive grants is 2 cycles.
- Boundary conditions:
  - Same cycle done and timeout: the tenure ends through the done path and timeout_pulse stays 0.
  - All req set continuously: grant order is 0,1,2,3,4,0,... with each grant lasting until its own done.
  - A single requester holding req: it is re-granted after the RELEASE+IDLE gap, so it cannot starve others and others cannot starve it.
  - grant_cnt wraps from 0xFFFF to 0.
  - grant is always one-hot or zero, and grant_id always matches the grant bit.
  - Pointer wrap: owner N_REQ-1 gives pointer 0.
- A competent implementation is a 3-state FSM plus a rotate/priority-encode arbiter, the tenure counter, and the grant counter.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with req=5'b11111 → grant=0, busy=0, grant_cnt=0. Release reset with req=5'b00100 → grant=5'b00100, grant_id=2 one cycle later, grant_cnt=1.
- Round-robin fairness: req=5'b11111 held; each owner pulses done on its 3rd grant cycle → grant sequence 0,1,2,3,4,0 with grant=0 for exactly 2 cycles between grants; grant_cnt=6.
- Timeout: req=5'b00010, no done, TIMEOUT=16 → grant held exactly 16 cycles, then timeout_pulse=1 for one cycle, grant=0, pointer=2. Also assert done on the same cycle as the timeout → timeout_pulse stays 0.
- Request drop: owner 3 deasserts req mid-tenure while req[0]=1 → grant clears on the next edge, and leaf 0 is granted 2 cycles later.
- Ignored foreign done: owner 1 granted, done=5'b10000 pulsed → no change. Then done=5'b00010 → release.
- Reset mid-tenure: owner 4 granted, rst_n=0 for one cycle → grant=0 and busy=0 on that edge. After reset with req=5'b10001 → leaf 0 is granted first (pointer reset to 0).
